rv_exec_unit: RTL and testbench
===============================

# rv_exec_unit

Parametrised integer execute unit for the RV32I pipeline. It is the successor to the single-op `mpu` datapath. It accepts RV32I OP (R-type) and OP-IMM (I-type) instructions over a valid/ready handshake, reads operands from an internal register file, and computes the result. Shifts run on an iterative multi-cycle shifter; all other ops complete in one cycle. Results are written back and reported on a write-back strobe, and a combinational debug read port gives the bench register visibility.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `NREGS`, 32, number of architectural registers; legal values are 2..32. Register x0 is hardwired to zero.
- `SHIFT_STEP`, 1, bits shifted per cycle by the iterative shifter; legal values are 1..XLEN.
- `R1_INIT`, 0, reset value of x1.
- `R2_INIT`, 0, reset value of x2.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  `instr` holds an instruction.
- `instr_ready`  out  1  unit can accept an instruction this cycle.
- `instr`  in  32  RV32I encoding.
- `wb_valid`  out  1  one-cycle strobe: an instruction has completed.
- `wb_addr`  out  5  rd of the completed instruction.
- `wb_data`  out  XLEN  result of the completed instruction.
- `illegal`  out  1  one-cycle strobe: the accepted instruction was not decodable.
- `dbg_addr`  in  5  debug read index.
- `dbg_data`  out  XLEN  combinational read of register `dbg_addr`; returns 0 for x0 or any index ≥ NREGS.

## Operation
- Supported opcodes:
  - 0110011 (OP): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 0010011 (OP-IMM): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- funct7 = 0100000 selects SUB/SRA/SRAI. funct7 = 0000000 selects all other ops. Any other funct7 is illegal.
- For XLEN = 64 the shift amount is instr[25:20] and the funct7 check uses instr[31:26]. For XLEN = 32 the shift amount is instr[24:20].
- The I-type immediate is instr[31:20], sign-extended to XLEN.
- The following are illegal: any other opcode, an undefined funct7, or rs1/rs2/rd ≥ NREGS.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; the result is 0 or 1, zero-extended.
- All arithmetic wraps modulo 2^XLEN.
- FSM states:
  - IDLE: `instr_ready` = 1.
  - SHIFT: `instr_ready` = 0.
- IDLE transitions on acceptance (`instr_valid` && `instr_ready`):
  - Illegal instruction: stay in IDLE.
  - Non-shift op, or shift with shamt = 0: compute and write back at the accept edge.
  - Shift with shamt > 0: apply the first step at the accept edge, load the remaining count, then go to SHIFT. If no count remains, write back at the accept edge.
- SHIFT: each edge shifts by min(SHIFT_STEP, remaining). When remaining reaches 0, write back and return to IDLE.
- Write-back edge actions:
  - regfile[rd] <= result, except when rd = 0 (no write).
  - `wb_valid` <= 1; `wb_addr` and `wb_data` carry rd and the computed result, including when rd = 0.
- On an illegal instruction: `illegal` <= 1, `wb_valid` stays 0, and no register changes.
- Operands are read at acceptance. Because write-back completes before the next acceptance, back-to-back dependent instructions see updated values; no hazard logic is needed.

## Timing
- Reset values:
  - State: IDLE.
  - `instr_ready` = 1; `wb_valid` = 0; `illegal` = 0.
  - `wb_addr` = 0; `wb_data` = 0.
  - x1 = R1_INIT, x2 = R2_INIT, all other registers = 0.
- Latency, with A = the accept cycle and L = max(1, ceil(shamt / SHIFT_STEP)):
  - `wb_valid` is high in cycle A+L only.
  - `instr_ready` is low in cycles A+1..A+L−1 and high in A+L.
  - `illegal` is high in cycle A+1 only.
- Throughput: one non-shift instruction per cycle.
- Input behaviour:
  - `instr` is ignored whenever `instr_ready` = 0; the sender must hold it until accepted.
  - `instr_valid` in SHIFT is not an error; it waits.
- Reset mid-SHIFT: the operation is abandoned, no write-back occurs, and all reset values apply the next cycle.
- `dbg_data` reflects a write in the cycle after the write-back edge.

## Test plan
- R1_INIT = −835, R2_INIT = 2, SHIFT_STEP = 1. Stimulus: `SRA x3,x1,x2`. Required: L = 2; `wb_valid` high in cycle A+2 with `wb_addr` = 3 and `wb_data` = 0xFFFFFF2F; `instr_ready` low in A+1; `dbg_data`(x3) = 0xFFFFFF2F.
- Same init. Stimulus: back-to-back `SLT x4,x1,x2`, then `SLTU x5,x1,x2`, then `ADD x6,x4,x5`. Required: x4 = 1, x5 = 0, x6 = 1; `wb_valid` high for 3 consecutive cycles.
- SHIFT_STEP = 4. Stimulus: `SLLI x6,x2,30`. Required: L = 8; `wb_data` = 0x80000000.
- Stimulus: `ADDI x0,x0,−1`, then `ADDI x7,x0,−1`. Required: first gives `wb_valid` with `wb_addr` = 0, `wb_data` = 0xFFFFFFFF and x0 still reads 0; second gives x7 = 0xFFFFFFFF.
- Stimulus: instr with funct7 = 0000001 (R-type), then opcode 0000011. Required: `illegal` pulses once per instruction, `wb_valid` stays 0, and all registers are unchanged.
- Stimulus: `reset` asserted in cycle A+3 of `SRL x8,x1,x2` with x2 = 20 and SHIFT_STEP = 1. Required: no `wb_valid`; x8 = 0; x1 and x2 return to their init values; `instr_ready` = 1 after reset.

Source files
------------

// File: rtl/rv_exec_unit.sv
// rtl/rv_exec_unit.sv - RV32I OP/OP-IMM execute unit with iterative shifter
//
// Purpose: accepts one OP or OP-IMM instruction per handshake, reads its
// operands from the internal register file and writes the result back.
// Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle.
// All other ops complete at the accept edge.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous active-high reset
//   instr_valid  instr holds an instruction
//   instr_ready  unit can accept this cycle (high in IDLE)
//   instr        RV32I encoding
//   wb_valid     one-cycle strobe: instruction completed
//   wb_addr      rd of the completed instruction
//   wb_data      result of the completed instruction
//   illegal      one-cycle strobe: accepted instruction was not decodable
//   dbg_addr     debug read index
//   dbg_data     combinational register read, 0 for x0 or index >= NREGS
module rv_exec_unit #(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter int              SHIFT_STEP = 1,
  parameter logic [XLEN-1:0] R1_INIT    = '0,
  parameter logic [XLEN-1:0] R2_INIT    = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int         SW   = (XLEN == 64) ? 6 : 5;
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_OPI = 7'b0010011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_regs [1:NREGS-1];  // x0 has no storage
  logic            r_wb_valid;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;
  logic [XLEN-1:0] r_sh_val;
  logic [SW-1:0]   r_sh_rem;
  logic            r_sh_left;
  logic            r_sh_arith;
  logic [4:0]      r_sh_rd;

  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] a);
    rd_reg = '0;
    for (int i = 1; i < NREGS; i++)
      if (a == 5'(i)) rd_reg = r_regs[i];
  endfunction

  function automatic logic [XLEN-1:0] do_shift(input logic [XLEN-1:0] v,
      input logic [SW:0] n, input logic left, input logic arith);
    if (left)       do_shift = v << n;
    else if (arith) do_shift = $signed(v) >>> n;
    else            do_shift = v >> n;
  endfunction

  // Bits to move this cycle: min(SHIFT_STEP, remaining).
  function automatic logic [SW:0] step_of(input logic [SW-1:0] rem);
    step_of = ({1'b0, rem} < STEP) ? {1'b0, rem} : STEP;
  endfunction

  function automatic logic in_rng(input logic [4:0] a);
    in_rng = (int'(a) < NREGS);
  endfunction

  logic [6:0]      w_opcode, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic            w_is_op, w_is_opi, w_is_shift, w_alt;
  logic            w_f7i_zero, w_f7i_alt, w_f7_ok, w_rng_ok, w_illegal;
  logic [XLEN-1:0] w_a, w_b_reg, w_b, w_imm, w_alu, w_first, w_sh_next;
  logic [SW-1:0]   w_shamt, w_rem0, w_rem_s;
  logic [SW:0]     w_step0, w_step_s;
  logic            w_ready, w_accept, w_wb;
  logic [4:0]      w_wb_addr;
  logic [XLEN-1:0] w_wb_data;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_f3     = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_f7     = instr[31:25];
  assign w_is_op  = (w_opcode == OPC_OP);
  assign w_is_opi = (w_opcode == OPC_OPI);
  assign w_imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};

  // Immediate shifts: the funct field sits above the shamt, so it is one bit
  // narrower when XLEN = 64 (shamt takes instr[25]).
  assign w_f7i_zero = (instr[31:20+SW] == '0);
  assign w_f7i_alt  = !instr[31] && instr[30] && (instr[29:20+SW] == '0);

  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  always_comb begin
    w_f7_ok = 1'b1;
    if (w_is_op)
      w_f7_ok = (w_f7 == 7'b0) ||
                ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    else if (w_f3 == 3'b001)
      w_f7_ok = w_f7i_zero;
    else if (w_f3 == 3'b101)
      w_f7_ok = w_f7i_zero || w_f7i_alt;
  end

  // rs2 field is immediate bits for OP-IMM, so only range-check it for OP.
  assign w_rng_ok  = in_rng(w_rs1) && in_rng(w_rd) && (!w_is_op || in_rng(w_rs2));
  assign w_illegal = !((w_is_op || w_is_opi) && w_f7_ok && w_rng_ok);

  assign w_a     = rd_reg(w_rs1);
  assign w_b_reg = rd_reg(w_rs2);
  assign w_b     = w_is_op ? w_b_reg : w_imm;
  assign w_alt   = w_is_op ? (w_f7 == F7_ALT) : w_f7i_alt;
  assign w_shamt = w_is_op ? w_b_reg[SW-1:0] : instr[20 +: SW];

  // First shift step is applied at the accept edge.
  assign w_step0 = step_of(w_shamt);
  assign w_first = do_shift(w_a, w_step0, w_f3 == 3'b001, w_alt && (w_f3 == 3'b101));
  assign w_rem0  = SW'({1'b0, w_shamt} - w_step0);

  assign w_step_s  = step_of(r_sh_rem);
  assign w_sh_next = do_shift(r_sh_val, w_step_s, r_sh_left, r_sh_arith);
  assign w_rem_s   = SW'({1'b0, r_sh_rem} - w_step_s);

  always_comb begin
    w_alu = w_first;
    case (w_f3)
      3'b000:  w_alu = (w_is_op && w_alt) ? (w_a - w_b) : (w_a + w_b);
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      3'b100:  w_alu = w_a ^ w_b;
      3'b110:  w_alu = w_a | w_b;
      3'b111:  w_alu = w_a & w_b;
      default: w_alu = w_first;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (instr_valid && !w_illegal && w_is_shift && (w_rem0 != '0))
          w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_rem_s == '0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept  = instr_valid && w_ready;
  assign w_wb      = (w_accept && !w_illegal && (!w_is_shift || (w_rem0 == '0))) ||
                     ((r_state == S_SHIFT) && (w_rem_s == '0));
  assign w_wb_addr = (r_state == S_SHIFT) ? r_sh_rd : w_rd;
  assign w_wb_data = (r_state == S_SHIFT) ? w_sh_next : w_alu;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++)
        r_regs[i] <= (i == 1) ? R1_INIT : (i == 2) ? R2_INIT : '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
      r_sh_val   <= '0;
      r_sh_rem   <= '0;
      r_sh_left  <= 1'b0;
      r_sh_arith <= 1'b0;
      r_sh_rd    <= '0;
    end else begin
      r_wb_valid <= w_wb;
      r_illegal  <= w_accept && w_illegal;
      if (w_wb) begin
        r_wb_addr <= w_wb_addr;
        r_wb_data <= w_wb_data;
        for (int i = 1; i < NREGS; i++)
          if (w_wb_addr == 5'(i)) r_regs[i] <= w_wb_data;
      end
      if (w_accept && !w_illegal && w_is_shift) begin
        r_sh_val   <= w_first;
        r_sh_rem   <= w_rem0;
        r_sh_left  <= (w_f3 == 3'b001);
        r_sh_arith <= w_alt && (w_f3 == 3'b101);
        r_sh_rd    <= w_rd;
      end else if (r_state == S_SHIFT) begin
        r_sh_val <= w_sh_next;
        r_sh_rem <= w_rem_s;
      end
    end
  end

  assign instr_ready = w_ready;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign illegal     = r_illegal;
  assign dbg_data    = rd_reg(dbg_addr);

endmodule

// File: tb/tb_rv_exec_unit.sv
// tb/tb_rv_exec_unit.sv - directed vector bench for rv_exec_unit
module tb_rv_exec_unit;

  localparam logic [31:0] X1I = 32'hFFFFFCBD;  // -835
  localparam logic [31:0] X2I = 32'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid, instr_valid4;
  logic [31:0] instr, instr4;
  logic        instr_ready, instr_ready4;
  logic        wb_valid, wb_valid4, illegal, illegal4;
  logic [4:0]  wb_addr, wb_addr4, dbg_addr, dbg_addr4;
  logic [31:0] wb_data, wb_data4, dbg_data, dbg_data4;

  always #5 clock = ~clock;

  rv_exec_unit #(.XLEN(32), .NREGS(32), .SHIFT_STEP(1), .R1_INIT(X1I), .R2_INIT(X2I)) u_dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  rv_exec_unit #(.XLEN(32), .NREGS(32), .SHIFT_STEP(4), .R1_INIT(X1I), .R2_INIT(X2I)) u_dut4 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid4), .instr_ready(instr_ready4),
    .instr(instr4), .wb_valid(wb_valid4), .wb_addr(wb_addr4), .wb_data(wb_data4),
    .illegal(illegal4), .dbg_addr(dbg_addr4), .dbg_data(dbg_data4));

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [32];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_dbg(input string name, input logic [4:0] r, input logic [31:0] exp);
    dbg_addr = r;
    #1;
    chk(name, dbg_data, exp);
  endtask

  // Apply one vector, then watch for lat+2 cycles after the accept edge.
  task automatic run_vec(input vec_t v, input int idx);
    int wb_cnt = 0, wb_cyc = 0, ill_cnt = 0, ill_cyc = 0, rdy_bad = 0;
    logic [4:0]  ga = '0;
    logic [31:0] gd = '0;
    logic        er;
    instr = v.instr;
    instr_valid = 1'b1;
    chk($sformatf("v%0d ready_before", idx), {31'b0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= v.lat + 2; c++) begin
      if (wb_valid) begin wb_cnt++; wb_cyc = c; ga = wb_addr; gd = wb_data; end
      if (illegal) begin ill_cnt++; ill_cyc = c; end
      er = v.ill ? 1'b1 : (c >= v.lat);
      if (instr_ready !== er) rdy_bad++;
      tick();
    end
    chk($sformatf("v%0d ready_profile", idx), rdy_bad, 0);
    if (v.ill) begin
      chk($sformatf("v%0d ill_count", idx), ill_cnt, 1);
      chk($sformatf("v%0d ill_cycle", idx), ill_cyc, 1);
      chk($sformatf("v%0d wb_count", idx), wb_cnt, 0);
    end else begin
      chk($sformatf("v%0d ill_count", idx), ill_cnt, 0);
      chk($sformatf("v%0d wb_count", idx), wb_cnt, 1);
      chk($sformatf("v%0d wb_cycle", idx), wb_cyc, v.lat);
      chk($sformatf("v%0d wb_addr", idx), {27'b0, ga}, {27'b0, v.rd});
      chk($sformatf("v%0d wb_data", idx), gd, v.data);
      if (v.rd != 5'd0) model[v.rd] = v.data;
      chk_dbg($sformatf("v%0d dbg_rd", idx), v.rd, model[v.rd]);
    end
  endtask

  initial begin
    int wb_cnt, wb_cyc, rdy_bad;
    logic [31:0] gd;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[1] = X1I;
    model[2] = X2I;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    instr_valid4 = 1'b0; instr4 = '0; dbg_addr4 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst ready", {31'b0, instr_ready}, 32'd1);
    chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst illegal", {31'b0, illegal}, 32'd0);
    chk("rst wb_addr", {27'b0, wb_addr}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk_dbg("rst x1", 5'd1, X1I);
    chk_dbg("rst x2", 5'd2, X2I);
    chk_dbg("rst x3", 5'd3, 32'd0);

    // SRA x3,x1,x2 with a follow-on instruction held during SHIFT
    instr = enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3);
    instr_valid = 1'b1;
    tick();
    chk("sra ready_A1", {31'b0, instr_ready}, 32'd0);
    chk("sra wb_A1", {31'b0, wb_valid}, 32'd0);
    instr = enc_i(12'd5, 5'd0, 3'b000, 5'd24);
    tick();
    chk("sra wb_A2", {31'b0, wb_valid}, 32'd1);
    chk("sra addr", {27'b0, wb_addr}, 32'd3);
    chk("sra data", wb_data, 32'hFFFFFF2F);
    chk("sra ready_A2", {31'b0, instr_ready}, 32'd1);
    chk_dbg("sra dbg_x3", 5'd3, 32'hFFFFFF2F);
    model[3] = 32'hFFFFFF2F;
    tick();
    instr_valid = 1'b0;
    chk("wait wb", {31'b0, wb_valid}, 32'd1);
    chk("wait addr", {27'b0, wb_addr}, 32'd24);
    chk("wait data", wb_data, 32'd5);
    model[24] = 32'd5;
    tick();
    chk("wait wb_off", {31'b0, wb_valid}, 32'd0);

    // back-to-back SLT, SLTU, dependent ADD
    instr = enc_r(7'b0, 5'd2, 5'd1, 3'b010, 5'd4);
    instr_valid = 1'b1;
    tick();
    chk("b2b slt wb", {31'b0, wb_valid}, 32'd1);
    chk("b2b slt addr", {27'b0, wb_addr}, 32'd4);
    chk("b2b slt data", wb_data, 32'd1);
    instr = enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd5);
    tick();
    chk("b2b sltu wb", {31'b0, wb_valid}, 32'd1);
    chk("b2b sltu addr", {27'b0, wb_addr}, 32'd5);
    chk("b2b sltu data", wb_data, 32'd0);
    instr = enc_r(7'b0, 5'd5, 5'd4, 3'b000, 5'd6);
    tick();
    instr_valid = 1'b0;
    chk("b2b add wb", {31'b0, wb_valid}, 32'd1);
    chk("b2b add addr", {27'b0, wb_addr}, 32'd6);
    chk("b2b add data", wb_data, 32'd1);
    model[4] = 32'd1; model[5] = 32'd0; model[6] = 32'd1;
    tick();
    chk("b2b wb_off", {31'b0, wb_valid}, 32'd0);

    // table of single instructions: {instr, illegal, rd, data, latency}
    vecs.push_back('{enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd10), 1'b0, 5'd10, 32'hFFFFFCBF, 1});
    vecs.push_back('{enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd11), 1'b0, 5'd11, 32'hFFFFFCBB, 1});
    vecs.push_back('{enc_r(7'b0, 5'd2, 5'd1, 3'b100, 5'd12), 1'b0, 5'd12, 32'hFFFFFCBF, 1});
    vecs.push_back('{enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd13), 1'b0, 5'd13, 32'hFFFFFCBF, 1});
    vecs.push_back('{enc_r(7'b0, 5'd2, 5'd1, 3'b111, 5'd14), 1'b0, 5'd14, 32'h00000000, 1});
    vecs.push_back('{enc_i(12'hFFF, 5'd1, 3'b000, 5'd15), 1'b0, 5'd15, 32'hFFFFFCBC, 1});
    vecs.push_back('{enc_i(12'hC7C, 5'd1, 3'b010, 5'd16), 1'b0, 5'd16, 32'd0, 1});
    vecs.push_back('{enc_i(12'hFFF, 5'd2, 3'b011, 5'd17), 1'b0, 5'd17, 32'd1, 1});
    vecs.push_back('{enc_i(12'h7FF, 5'd2, 3'b100, 5'd18), 1'b0, 5'd18, 32'h000007FD, 1});
    vecs.push_back('{enc_i(12'h001, 5'd2, 3'b110, 5'd19), 1'b0, 5'd19, 32'd3, 1});
    vecs.push_back('{enc_i(12'h0FF, 5'd1, 3'b111, 5'd20), 1'b0, 5'd20, 32'h000000BD, 1});
    vecs.push_back('{enc_i(12'h000, 5'd2, 3'b001, 5'd21), 1'b0, 5'd21, 32'd2, 1});
    vecs.push_back('{enc_r(7'b0, 5'd0, 5'd2, 3'b001, 5'd22), 1'b0, 5'd22, 32'd2, 1});
    vecs.push_back('{enc_i(12'h001, 5'd1, 3'b101, 5'd23), 1'b0, 5'd23, 32'h7FFFFE5E, 1});
    vecs.push_back('{enc_r(7'b0, 5'd2, 5'd1, 3'b101, 5'd25), 1'b0, 5'd25, 32'h3FFFFF2F, 2});
    vecs.push_back('{enc_r(7'b0, 5'd2, 5'd2, 3'b001, 5'd26), 1'b0, 5'd26, 32'd8, 2});
    vecs.push_back('{enc_i(12'h401, 5'd1, 3'b101, 5'd27), 1'b0, 5'd27, 32'hFFFFFE5E, 1});
    vecs.push_back('{enc_i(12'hFFF, 5'd0, 3'b000, 5'd0), 1'b0, 5'd0, 32'hFFFFFFFF, 1});
    vecs.push_back('{enc_i(12'hFFF, 5'd0, 3'b000, 5'd7), 1'b0, 5'd7, 32'hFFFFFFFF, 1});
    vecs.push_back('{enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd9), 1'b1, 5'd9, 32'd0, 1});
    vecs.push_back('{(enc_i(12'h0, 5'd1, 3'b010, 5'd9) & ~32'h7F) | 32'h03, 1'b1, 5'd9, 32'd0, 1});
    vecs.push_back('{enc_r(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd9), 1'b1, 5'd9, 32'd0, 1});
    vecs.push_back('{enc_i(12'h405, 5'd1, 3'b001, 5'd9), 1'b1, 5'd9, 32'd0, 1});
    foreach (vecs[i]) run_vec(vecs[i], i);

    // whole register file against the model (illegal ones changed nothing)
    for (int r = 0; r < 32; r++) chk_dbg($sformatf("regfile x%0d", r), 5'(r), model[r]);
    tick();

    // SLLI x6,x2,30 with SHIFT_STEP = 4: eight cycles
    instr4 = enc_i(12'd30, 5'd2, 3'b001, 5'd6);
    instr_valid4 = 1'b1;
    tick();
    instr_valid4 = 1'b0;
    wb_cnt = 0; wb_cyc = 0; rdy_bad = 0; gd = '0;
    for (int c = 1; c <= 10; c++) begin
      if (wb_valid4) begin wb_cnt++; wb_cyc = c; gd = wb_data4; end
      if (instr_ready4 !== (c >= 8)) rdy_bad++;
      tick();
    end
    chk("slli4 wb_count", wb_cnt, 1);
    chk("slli4 wb_cycle", wb_cyc, 8);
    chk("slli4 data", gd, 32'h80000000);
    chk("slli4 ready_profile", rdy_bad, 0);
    dbg_addr4 = 5'd6;
    #1;
    chk("slli4 dbg_x6", dbg_data4, 32'h80000000);

    // reset in cycle A+3 of a 20-cycle SRL
    run_vec('{enc_i(12'd20, 5'd0, 3'b000, 5'd2), 1'b0, 5'd2, 32'd20, 1}, 99);
    instr = enc_r(7'b0, 5'd2, 5'd1, 3'b101, 5'd8);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    wb_cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      if (wb_valid) wb_cnt++;
      reset = (c == 3);
      tick();
      if (c == 3) begin
        chk("rstmid ready", {31'b0, instr_ready}, 32'd1);
        chk("rstmid wb_addr", {27'b0, wb_addr}, 32'd0);
        chk("rstmid wb_data", wb_data, 32'd0);
      end
    end
    reset = 1'b0;
    chk("rstmid wb_count", wb_cnt, 0);
    chk("rstmid ready_end", {31'b0, instr_ready}, 32'd1);
    chk_dbg("rstmid x8", 5'd8, 32'd0);
    chk_dbg("rstmid x1", 5'd1, X1I);
    chk_dbg("rstmid x2", 5'd2, X2I);
    chk_dbg("rstmid x7", 5'd7, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
